// File: rtl/onehot_decoder_hold.sv
// onehot_decoder_hold
//   Registered binary-to-one-hot decoder with a valid/ready input handshake.
//   An accepted legal code k (1..MAX_CODE) drives decoder_out[k] for HOLD
//   cycles, followed by one all-zero GAP cycle. Code 0 is consumed silently.
//   Codes above MAX_CODE are consumed and flagged with a one-cycle err pulse.
//
//   Optional build macro: DECODER_SKID_EN
//     Adds a one-entry skid register so a new code can be accepted during
//     HOLD/GAP and started directly at GAP exit. Without it, codes are
//     accepted only in IDLE.
//
// Parameters
//   WIDTH     code width; decoder_out is 2**WIDTH bits
//   MAX_CODE  highest legal code
//   HOLD      cycles each one-hot output is held (1..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       block enable; low blocks acceptance and aborts a hold
//   binary_in    code to decode
//   in_valid     binary_in valid
//   in_ready     block can accept (combinational)
//   decoder_out  registered one-hot output
//   out_valid    decoder_out carries a code
//   err          one-cycle pulse for a rejected code
module onehot_decoder_hold #(
  parameter int WIDTH    = 4,
  parameter int MAX_CODE = 6,
  parameter int HOLD     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      binary_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2**WIDTH-1:0]   decoder_out,
  output logic                  out_valid,
  output logic                  err
);

  localparam int OUT_W = 2**WIDTH;
  localparam int CNT_W = $clog2(HOLD + 1);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_CODE);
  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [OUT_W-1:0]   dec_nxt;
  logic               out_valid_nxt;
  logic               err_nxt;

  logic               xfer;
  logic               take;
  logic [WIDTH-1:0]   take_code;
  logic               take_hold;
  logic               take_rej;

`ifdef DECODER_SKID_EN
  logic               skid_full;
  logic               skid_full_nxt;
  logic [WIDTH-1:0]   skid_code;
`endif

  function automatic logic [OUT_W-1:0] onehot(input logic [WIDTH-1:0] c);
    return OUT_W'(1) << c;
  endfunction

  // Ready is gated by rst_n so it drops the moment reset asserts.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      S_IDLE:        in_ready = enable;
`ifdef DECODER_SKID_EN
      S_HOLD, S_GAP: in_ready = enable && !skid_full;
`endif
      default:       in_ready = 1'b0;
    endcase
    in_ready = in_ready && rst_n;
  end

  assign xfer = in_valid && in_ready;

  // Code handed to the decode step this cycle. In IDLE it is the live
  // transfer; at GAP exit it is the skid entry, or a transfer that arrives
  // during GAP while the skid is empty (passed straight through).
  always_comb begin
    take      = 1'b0;
    take_code = binary_in;
    if (state == S_IDLE) begin
      take = xfer;
    end
`ifdef DECODER_SKID_EN
    else if (state == S_GAP) begin
      take      = skid_full || xfer;
      take_code = skid_full ? skid_code : binary_in;
    end
`endif
  end

  assign take_hold = take && (take_code != '0) && (take_code <= MAX_C);
  assign take_rej  = take && (take_code > MAX_C);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (take_hold) state_nxt = S_HOLD;
      S_HOLD: if (!enable || (cnt == CNT_ONE)) state_nxt = S_GAP;
      S_GAP:  state_nxt = take_hold ? S_HOLD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- output / counter next values ----
  // The counter only decrements while staying in HOLD, which requires
  // cnt > 1, so it can never wrap.
  always_comb begin
    cnt_nxt       = '0;
    dec_nxt       = '0;
    out_valid_nxt = (state_nxt == S_HOLD);
    err_nxt       = take_rej;
    if (state_nxt == S_HOLD) begin
      if (state == S_HOLD) begin
        cnt_nxt = cnt - CNT_ONE;
        dec_nxt = decoder_out;
      end else begin
        cnt_nxt = HOLD_C;
        dec_nxt = onehot(take_code);
      end
    end
  end

  // ---- output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      decoder_out <= '0;
      out_valid   <= 1'b0;
      err         <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      decoder_out <= dec_nxt;
      out_valid   <= out_valid_nxt;
      err         <= err_nxt;
    end
  end

`ifdef DECODER_SKID_EN
  // Skid fills only from a HOLD-time transfer; dropping enable in HOLD
  // discards it, and GAP always empties it (consumed at GAP exit).
  always_comb begin
    skid_full_nxt = 1'b0;
    if (state == S_HOLD) begin
      skid_full_nxt = enable && (skid_full || xfer);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
    end else begin
      skid_full <= skid_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_HOLD) && xfer) begin
      skid_code <= binary_in;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Testbench for onehot_decoder_hold (WIDTH=4, MAX_CODE=6, HOLD=3).
// A timeline model tracks, in absolute cycle numbers, when the current hold
// window and gap fall and when an err pulse is due; a compare process checks
// every cycle, and directed sequences pin literal values.
module tb_onehot_decoder_hold;

  localparam int WIDTH    = 4;
  localparam int MAX_CODE = 6;
  localparam int HOLD     = 3;
  localparam int OUT_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] binary_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] decoder_out;
  logic             out_valid;
  logic             err;

  int tests = 0;
  int fails = 0;

  onehot_decoder_hold #(
    .WIDTH(WIDTH), .MAX_CODE(MAX_CODE), .HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .binary_in(binary_in),
    .in_valid(in_valid), .in_ready(in_ready), .decoder_out(decoder_out),
    .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int               cyc = 0;
  int               hold_start = -1;
  int               hold_end = -1;
  int               gap_cyc = -1;
  int               err_cyc = -1;
  int               m_code = 0;
  int               skid_q[$];
  logic [OUT_W-1:0] m_out = '0;
  logic             m_vld = 1'b0;
  logic             m_err = 1'b0;

  function automatic logic model_ready();
    if (!rst_n) return 1'b0;
    if (cyc > gap_cyc) return enable;
`ifdef DECODER_SKID_EN
    return enable && (skid_q.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_take(input int code, input int c);
    if (code == 0) begin
    end else if (code > MAX_CODE) begin
      err_cyc = c + 1;
    end else begin
      m_code     = code;
      hold_start = c + 1;
      hold_end   = c + HOLD;
      gap_cyc    = c + HOLD + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hold_start = -1; hold_end = -1; gap_cyc = -1; err_cyc = -1;
        skid_q.delete();
        m_out = '0; m_vld = 1'b0; m_err = 1'b0;
      end else begin
        automatic int   c    = cyc;
        automatic logic rdy  = model_ready();
        automatic logic xf   = in_valid && rdy;
        automatic logic hold = (c >= hold_start) && (c <= hold_end);
        automatic logic busy = (c <= gap_cyc);
        if (hold && !enable) begin
          hold_end = c;
          gap_cyc  = c + 1;
          skid_q.delete();
        end else if (busy) begin
`ifdef DECODER_SKID_EN
          if (xf) skid_q.push_back(int'(binary_in));
          if ((c == gap_cyc) && (skid_q.size() > 0)) model_take(skid_q.pop_front(), c);
`endif
        end else if (xf) begin
          model_take(int'(binary_in), c);
        end
        cyc   = c + 1;
        m_vld = (cyc >= hold_start) && (cyc <= hold_end);
        m_out = m_vld ? (OUT_W'(1) << m_code) : '0;
        m_err = (err_cyc == cyc);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_decoder_out", 32'(decoder_out), 32'(m_out));
      check("cmp_out_valid",   32'(out_valid),   32'(m_vld));
      check("cmp_err",         32'(err),         32'(m_err));
      check("cmp_in_ready",    32'(in_ready),    32'(model_ready()));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int codes5 [3];
  int idx5;
  int first2;
  int first40;
  logic took;

  initial begin
    #12;
    @(negedge clk);
    check("rst_dec",   32'(decoder_out), 32'h0);
    check("rst_vld",   32'(out_valid),   32'h0);
    check("rst_err",   32'(err),         32'h0);
    check("rst_ready", 32'(in_ready),    32'h0);
    next_cycle();
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'h1);

    // Code 3: held three cycles, one gap, ready again after that
    next_cycle();
    in_valid = 1'b1; binary_in = 4'd3;
    @(negedge clk);
    check("t1_ready_at_xfer", 32'(in_ready), 32'h1);
    next_cycle();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        check("t1_dec", 32'(decoder_out), 32'h0008);
        check("t1_vld", 32'(out_valid), 32'h1);
      end else if (k == 4) begin
        check("t1_gap_dec",   32'(decoder_out), 32'h0);
        check("t1_gap_vld",   32'(out_valid),   32'h0);
        check("t1_gap_ready", 32'(in_ready),    32'h0);
      end else begin
        check("t1_ready_back", 32'(in_ready), 32'h1);
      end
      next_cycle();
    end

    // Code 0 then code 7 back to back: no output, err one cycle after 7
    in_valid = 1'b1; binary_in = 4'd0;
    @(negedge clk);
    check("t2_ready0", 32'(in_ready), 32'h1);
    next_cycle();
    binary_in = 4'd7;
    @(negedge clk);
    check("t2_ready1", 32'(in_ready), 32'h1);
    check("t2_err_early", 32'(err), 32'h0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_err", 32'(err), 32'h1);
    check("t2_vld", 32'(out_valid), 32'h0);
    check("t2_ready2", 32'(in_ready), 32'h1);
    next_cycle();
    @(negedge clk);
    check("t2_err_end", 32'(err), 32'h0);

    // Code 5 with enable dropped in its second hold cycle
    next_cycle();
    in_valid = 1'b1; binary_in = 4'd5;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_dec1", 32'(decoder_out), 32'h0020);
    next_cycle();
    enable = 1'b0;
    @(negedge clk);
    check("t3_dec2", 32'(decoder_out), 32'h0020);
    check("t3_ready_off", 32'(in_ready), 32'h0);
    next_cycle();
    @(negedge clk);
    check("t3_abort_dec", 32'(decoder_out), 32'h0);
    check("t3_abort_vld", 32'(out_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("t3_idle_disabled", 32'(in_ready), 32'h0);
    next_cycle();
    enable = 1'b1;
    @(negedge clk);
    check("t3_idle_enabled", 32'(in_ready), 32'h1);

    // Asynchronous reset in the middle of a hold for code 2
    next_cycle();
    in_valid = 1'b1; binary_in = 4'd2;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_dec", 32'(decoder_out), 32'h0004);
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_dec",   32'(decoder_out), 32'h0);
    check("t4_rst_vld",   32'(out_valid),   32'h0);
    check("t4_rst_ready", 32'(in_ready),    32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_idle_ready", 32'(in_ready), 32'h1);
    next_cycle();
    in_valid = 1'b1; binary_in = 4'd1;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_after_dec", 32'(decoder_out), 32'h0002);
    check("t4_after_vld", 32'(out_valid), 32'h1);
    repeat (5) next_cycle();

    // Codes 1, 6, 3 offered continuously; each advances on handshake
    codes5[0] = 1; codes5[1] = 6; codes5[2] = 3;
    idx5 = 0; first2 = -1; first40 = -1;
    in_valid = 1'b1; binary_in = WIDTH'(codes5[0]);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((decoder_out == 16'h0002) && (first2 < 0)) first2 = k;
      if ((decoder_out == 16'h0040) && (first40 < 0)) first40 = k;
      if (k == 2) check("t5_refused", 32'(in_ready), 32'h0);
      took = in_valid && model_ready();
      next_cycle();
      if (took) begin
        idx5++;
        if (idx5 < 3) binary_in = WIDTH'(codes5[idx5]);
        else in_valid = 1'b0;
      end
    end
    check("t5_first_code1", 32'(first2), 32'd1);
`ifdef DECODER_SKID_EN
    check("t5_spacing", 32'(first40 - first2), 32'(HOLD + 1));
`else
    check("t5_spacing", 32'(first40 - first2), 32'(HOLD + 2));
`endif
    check("t5_all_taken", 32'(idx5), 32'd3);
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
